// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the RV32 ID/EX pipeline
//               register: packed control bundle, bubble encoding and
//               ResultSrc encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int ALU_CTRL_W = 4;

    // ResultSrc encodings selecting the value written back to the register file
    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    typedef struct packed {
        logic                  RegWrite;
        logic [1:0]            ResultSrc;
        logic                  MemWrite;
        logic                  Jump;
        logic                  Branch;
        logic [ALU_CTRL_W-1:0] ALUControl;
        logic                  ALUSrc;
        logic                  JALR;
    } ctrl_t;

    // All-zero control word: an instruction that changes no architectural state
    localparam ctrl_t CTRL_NOP = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/idex_reg_hz_if.sv
`default_nettype none
// ============================================================================
// Module      : idex_reg_hz_if
// Description : D-side inputs, hazard controls, E-side outputs and counters
//               of the ID/EX pipeline register, bundled as one interface.
// Revision    : 1.0 - initial release
// ============================================================================
interface idex_reg_hz_if
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 16
);
    // Hazard controls
    logic                  StallE;
    logic                  FlushE;
    logic                  CntClr;

    // Decode-stage side
    logic                  ValidD;
    ctrl_t                 CtrlD;
    logic [2:0]            funct3D;
    logic [REG_ADDR_W-1:0] Rs1D;
    logic [REG_ADDR_W-1:0] Rs2D;
    logic [REG_ADDR_W-1:0] RdD;
    logic [DATA_WIDTH-1:0] PCD;
    logic [DATA_WIDTH-1:0] PCPlus4D;
    logic [DATA_WIDTH-1:0] RD1D;
    logic [DATA_WIDTH-1:0] RD2D;
    logic [DATA_WIDTH-1:0] ImmExtD;

    // Execute-stage side
    logic                  ValidE;
    ctrl_t                 CtrlE;
    logic [2:0]            funct3E;
    logic [REG_ADDR_W-1:0] Rs1E;
    logic [REG_ADDR_W-1:0] Rs2E;
    logic [REG_ADDR_W-1:0] RdE;
    logic [DATA_WIDTH-1:0] PCE;
    logic [DATA_WIDTH-1:0] PCPlus4E;
    logic [DATA_WIDTH-1:0] RD1E;
    logic [DATA_WIDTH-1:0] RD2E;
    logic [DATA_WIDTH-1:0] ImmExtE;

    // Performance counters
    logic [CNT_WIDTH-1:0]  StallCount;
    logic [CNT_WIDTH-1:0]  BubbleCount;

    // Producer of D-stage values and hazard controls
    modport master (
        output StallE, FlushE, CntClr,
        output ValidD, CtrlD, funct3D, Rs1D, Rs2D, RdD,
        output PCD, PCPlus4D, RD1D, RD2D, ImmExtD,
        input  ValidE, CtrlE, funct3E, Rs1E, Rs2E, RdE,
        input  PCE, PCPlus4E, RD1E, RD2E, ImmExtE,
        input  StallCount, BubbleCount
    );

    // The pipeline register itself
    modport slave (
        input  StallE, FlushE, CntClr,
        input  ValidD, CtrlD, funct3D, Rs1D, Rs2D, RdD,
        input  PCD, PCPlus4D, RD1D, RD2D, ImmExtD,
        output ValidE, CtrlE, funct3E, Rs1E, Rs2E, RdE,
        output PCE, PCPlus4E, RD1E, RD2E, ImmExtE,
        output StallCount, BubbleCount
    );

endinterface : idex_reg_hz_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear; clear wins over
//               a same-cycle increment, and the count sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic [W-1:0]      count
);

    // Count events, holding at the maximum instead of wrapping
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/idex_reg_hz.sv
`default_nettype none
// ============================================================================
// Module      : idex_reg_hz
// Description : ID/EX pipeline register with stall (hold), flush (bubble),
//               valid tracking and saturating stall/bubble counters.
// Revision    : 1.0 - initial release
// ============================================================================
module idex_reg_hz
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int REG_ADDR_W          = 5,
    parameter int CNT_WIDTH           = 16,
    parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    idex_reg_hz_if.slave  bus
);

    // A flush overrides a stall, so only a flush-free stall counts as a stall
    logic w_stall_inc;
    assign w_stall_inc = bus.StallE & ~bus.FlushE;

    // Pipeline fields: rst > flush > stall (hold) > load
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ValidE   <= 1'b0;
            bus.CtrlE    <= CTRL_NOP;
            bus.funct3E  <= '0;
            bus.Rs1E     <= '0;
            bus.Rs2E     <= '0;
            bus.RdE      <= '0;
            bus.PCE      <= '0;
            bus.PCPlus4E <= '0;
            bus.RD1E     <= '0;
            bus.RD2E     <= '0;
            bus.ImmExtE  <= '0;
        end else if (bus.FlushE) begin
            // Bubble: everything that can change state or trigger forwarding is cleared
            bus.ValidE  <= 1'b0;
            bus.CtrlE   <= CTRL_NOP;
            bus.funct3E <= '0;
            bus.Rs1E    <= '0;
            bus.Rs2E    <= '0;
            bus.RdE     <= '0;
            if (CLEAR_DATA_ON_FLUSH) begin
                bus.PCE      <= '0;
                bus.PCPlus4E <= '0;
                bus.RD1E     <= '0;
                bus.RD2E     <= '0;
                bus.ImmExtE  <= '0;
            end else begin
                bus.PCE      <= bus.PCD;
                bus.PCPlus4E <= bus.PCPlus4D;
                bus.RD1E     <= bus.RD1D;
                bus.RD2E     <= bus.RD2D;
                bus.ImmExtE  <= bus.ImmExtD;
            end
        end else if (!bus.StallE) begin
            // An invalid instruction is neutered so it can never write RF or memory
            bus.ValidE   <= bus.ValidD;
            bus.CtrlE    <= bus.ValidD ? bus.CtrlD : CTRL_NOP;
            bus.funct3E  <= bus.funct3D;
            bus.Rs1E     <= bus.Rs1D;
            bus.Rs2E     <= bus.Rs2D;
            bus.RdE      <= bus.ValidD ? bus.RdD : '0;
            bus.PCE      <= bus.PCD;
            bus.PCPlus4E <= bus.PCPlus4D;
            bus.RD1E     <= bus.RD1D;
            bus.RD2E     <= bus.RD2D;
            bus.ImmExtE  <= bus.ImmExtD;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.CntClr),
        .inc   (w_stall_inc),
        .count (bus.StallCount)
    );

    sat_counter #(.W(CNT_WIDTH)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.CntClr),
        .inc   (bus.FlushE),
        .count (bus.BubbleCount)
    );

endmodule : idex_reg_hz
`default_nettype wire

// File: tb/tb_idex_reg_hz.sv
`default_nettype none
// ============================================================================
// Module      : tb_idex_reg_hz
// Description : Scoreboard bench for idex_reg_hz. Directed stimulus pushes
//               hand-computed E-stage expectations; a monitor compares them
//               one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idex_reg_hz;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef struct packed {
        logic          valid;
        ctrl_t         ctrl;
        logic [2:0]    f3;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic [AW-1:0] rd;
        logic [DW-1:0] pc;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [CW-1:0] sc;
        logic [CW-1:0] bc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    ctrl_t c_rw, c_mw, c_both;
    exp_t  e_zero, e_hold;

    idex_reg_hz_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .CNT_WIDTH(CW)) bus ();

    idex_reg_hz #(
        .DATA_WIDTH          (DW),
        .REG_ADDR_W          (AW),
        .CNT_WIDTH           (CW),
        .CLEAR_DATA_ON_FLUSH (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Data fields follow a fixed pattern of the PC so one value describes them all
    function automatic exp_t mk(input logic v, input ctrl_t c, input logic [2:0] f3,
                                input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                input logic [AW-1:0] rd, input logic [DW-1:0] pc,
                                input logic [CW-1:0] sc, input logic [CW-1:0] bc);
        exp_t e;
        e.valid = v;  e.ctrl = c;  e.f3 = f3;
        e.rs1 = r1;   e.rs2 = r2;  e.rd = rd;
        e.pc  = pc;   e.pc4 = pc + 32'd4;
        e.rd1 = pc + 32'h1000; e.rd2 = pc + 32'h2000; e.imm = pc + 32'h3000;
        e.sc  = sc;   e.bc  = bc;
        return e;
    endfunction

    // Drive one cycle of D-side stimulus and record what E must show after the edge
    task automatic step(input logic r, input logic st, input logic fl, input logic clr,
                        input logic v, input ctrl_t c, input logic [2:0] f3,
                        input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] rd, input logic [DW-1:0] pc, input exp_t e);
        @(negedge clk);
        rst          = r;
        bus.StallE   = st;
        bus.FlushE   = fl;
        bus.CntClr   = clr;
        bus.ValidD   = v;
        bus.CtrlD    = c;
        bus.funct3D  = f3;
        bus.Rs1D     = r1;
        bus.Rs2D     = r2;
        bus.RdD      = rd;
        bus.PCD      = pc;
        bus.PCPlus4D = pc + 32'd4;
        bus.RD1D     = pc + 32'h1000;
        bus.RD2D     = pc + 32'h2000;
        bus.ImmExtD  = pc + 32'h3000;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every edge with an outstanding expectation is checked field by field
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("ValidE",      DW'(bus.ValidE),      DW'(e.valid));
                chk("CtrlE",       DW'(bus.CtrlE),       DW'(e.ctrl));
                chk("funct3E",     DW'(bus.funct3E),     DW'(e.f3));
                chk("Rs1E",        DW'(bus.Rs1E),        DW'(e.rs1));
                chk("Rs2E",        DW'(bus.Rs2E),        DW'(e.rs2));
                chk("RdE",         DW'(bus.RdE),         DW'(e.rd));
                chk("PCE",         bus.PCE,              e.pc);
                chk("PCPlus4E",    bus.PCPlus4E,         e.pc4);
                chk("RD1E",        bus.RD1E,             e.rd1);
                chk("RD2E",        bus.RD2E,             e.rd2);
                chk("ImmExtE",     bus.ImmExtE,          e.imm);
                chk("StallCount",  DW'(bus.StallCount),  DW'(e.sc));
                chk("BubbleCount", DW'(bus.BubbleCount), DW'(e.bc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        c_rw   = CTRL_NOP; c_rw.RegWrite = 1'b1; c_rw.ResultSrc = RESULT_MEM;
        c_rw.ALUControl = 4'b0010; c_rw.ALUSrc = 1'b1;
        c_mw   = CTRL_NOP; c_mw.MemWrite = 1'b1; c_mw.ALUSrc = 1'b1;
        c_both = c_rw;     c_both.MemWrite = 1'b1; c_both.JALR = 1'b1;
        e_zero = '0;

        // Reset with busy D inputs -> everything zero
        step(1, 0, 0, 0, 1, c_rw, 3'b101, 5'd1, 5'd2, 5'd3, 32'h100, e_zero);
        // Plain load
        step(0, 0, 0, 0, 1, c_rw, 3'd2, 5'd1, 5'd2, 5'd7, 32'h40,
             mk(1, c_rw, 3'd2, 5'd1, 5'd2, 5'd7, 32'h40, 4'd0, 4'd0));
        // Three stall cycles while D moves on to 0x44
        e_hold = mk(1, c_rw, 3'd2, 5'd1, 5'd2, 5'd7, 32'h40, 4'd0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            e_hold.sc = CW'(i);
            step(0, 1, 0, 0, 1, c_rw, 3'd3, 5'd3, 5'd4, 5'd8, 32'h44, e_hold);
        end
        // First unstalled edge picks up 0x44
        step(0, 0, 0, 0, 1, c_rw, 3'd3, 5'd3, 5'd4, 5'd8, 32'h44,
             mk(1, c_rw, 3'd3, 5'd3, 5'd4, 5'd8, 32'h44, 4'd3, 4'd0));
        // Flush + stall: bubble, data still loads, StallCount unchanged
        step(0, 1, 1, 0, 1, c_mw, 3'd1, 5'd6, 5'd7, 5'd5, 32'h48,
             mk(0, CTRL_NOP, 3'd0, 5'd0, 5'd0, 5'd0, 32'h48, 4'd3, 4'd1));
        // Invalid instruction: control and Rd neutered, rest loads
        step(0, 0, 0, 0, 0, c_both, 3'd4, 5'd10, 5'd11, 5'd9, 32'h4c,
             mk(0, CTRL_NOP, 3'd4, 5'd10, 5'd11, 5'd0, 32'h4c, 4'd3, 4'd1));
        // Flush alone
        step(0, 0, 1, 0, 1, c_rw, 3'd6, 5'd12, 5'd13, 5'd3, 32'h50,
             mk(0, CTRL_NOP, 3'd0, 5'd0, 5'd0, 5'd0, 32'h50, 4'd3, 4'd2));
        // 20 stalls: StallCount climbs from 3 and sticks at 15
        e_hold = mk(0, CTRL_NOP, 3'd0, 5'd0, 5'd0, 5'd0, 32'h50, 4'd3, 4'd2);
        for (int i = 1; i <= 20; i++) begin
            e_hold.sc = (3 + i > 15) ? 4'd15 : CW'(3 + i);
            step(0, 1, 0, 0, 1, c_rw, 3'd7, 5'd14, 5'd15, 5'd4, 32'h54, e_hold);
        end
        // Clear beats a same-cycle stall increment; fields still held
        e_hold.sc = 4'd0; e_hold.bc = 4'd0;
        step(0, 1, 0, 1, 1, c_rw, 3'd7, 5'd14, 5'd15, 5'd4, 32'h54, e_hold);
        // Clear beats a same-cycle bubble increment
        step(0, 0, 1, 1, 1, c_rw, 3'd7, 5'd14, 5'd15, 5'd4, 32'h58,
             mk(0, CTRL_NOP, 3'd0, 5'd0, 5'd0, 5'd0, 32'h58, 4'd0, 4'd0));
        // Load, then reset in the middle of a stall
        step(0, 0, 0, 0, 1, c_rw, 3'd2, 5'd16, 5'd17, 5'd12, 32'h60,
             mk(1, c_rw, 3'd2, 5'd16, 5'd17, 5'd12, 32'h60, 4'd0, 4'd0));
        step(1, 1, 0, 0, 1, c_mw, 3'd5, 5'd18, 5'd19, 5'd13, 32'h64, e_zero);
        // Recovery after reset, then one stall counted from zero
        step(0, 0, 0, 0, 1, c_mw, 3'd5, 5'd18, 5'd19, 5'd13, 32'h68,
             mk(1, c_mw, 3'd5, 5'd18, 5'd19, 5'd13, 32'h68, 4'd0, 4'd0));
        step(0, 1, 0, 0, 1, c_rw, 3'd1, 5'd20, 5'd21, 5'd14, 32'h6c,
             mk(1, c_mw, 3'd5, 5'd18, 5'd19, 5'd13, 32'h68, 4'd1, 4'd0));

        // Let the monitor drain, bounded by a few cycles
        @(negedge clk);
        bus.StallE = 1'b1;
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_idex_reg_hz
`default_nettype wire

// File: doc/idex_reg_hz.md
Name: idex_reg_hz

Overview:
- Parametrised ID/EX pipeline register for the pipelined RV32 core.
- Adds the hazard-control behaviour needed once the hazard unit is connected: stall (hold), flush (bubble insertion) and a valid bit.
- Every field, funct3 included, has a defined reset value.
- Includes saturating stall and bubble performance counters, readable by the debug/perf logic.

Parameters:
- DATA_WIDTH, 32, width of PC, PCPlus4, RD1, RD2 and ImmExt fields.
- REG_ADDR_W, 5, register-index width for Rs1, Rs2 and Rd.
- CNT_WIDTH, 16, width of each performance counter.
- CLEAR_DATA_ON_FLUSH, 0: 1 = flush also zeroes the data fields; 0 = data fields load from D as normal during a flush.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- StallE  in  1  hold all E-stage fields.
- FlushE  in  1  load a bubble into the E stage.
- CntClr  in  1  synchronous clear of both counters.
- ValidD  in  1  D-stage instruction valid.
- CtrlD  in  ctrl_t  packed control: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[3:0], ALUSrc, JALR.
- funct3D  in  3  funct3 field.
- Rs1D, Rs2D, RdD  in  REG_ADDR_W each  register indices.
- PCD, PCPlus4D, RD1D, RD2D, ImmExtD  in  DATA_WIDTH each  D-stage data.
- ValidE  out  1  E-stage instruction valid.
- CtrlE  out  ctrl_t  registered control.
- funct3E  out  3  registered funct3.
- Rs1E, Rs2E, RdE  out  REG_ADDR_W  registered indices (Rs1E/Rs2E drive the forwarding unit).
- PCE, PCPlus4E, RD1E, RD2E, ImmExtE  out  DATA_WIDTH  registered data.
- StallCount  out  CNT_WIDTH  cycles in which a stall was applied.
- BubbleCount  out  CNT_WIDTH  bubbles inserted by flush.

Behaviour:
- Reset: clock and reset are a single clock clk with synchronous, active-high reset rst. On rst, every output is 0: ValidE, CtrlE (= CTRL_NOP), funct3E, Rs1E, Rs2E, RdE, all data fields and both counters.
- Latency: 1 cycle from D inputs to E outputs. No combinational path from any input to any output.
- Priority each rising edge: rst > FlushE > StallE > load.
- Flush (FlushE=1):
  - ValidE, CtrlE, funct3E, Rs1E, Rs2E and RdE are set to 0.
  - Data fields are zeroed if CLEAR_DATA_ON_FLUSH=1; otherwise they load from D.
  - Flush overrides a simultaneous stall. StallE=1 with FlushE=1 produces a bubble, not a hold.
- Stall (StallE=1, FlushE=0): all E fields hold their current values, including ValidE.
- Load (neither asserted): every E field takes its D counterpart.
  - If ValidD=0, CtrlE is forced to CTRL_NOP and RdE to 0. Data fields still load.
  - An invalid instruction therefore never writes the register file or memory.
- StallCount:
  - Increments on each edge where StallE=1, FlushE=0 and rst=0.
  - Saturates at all-ones; no wrap.
- BubbleCount:
  - Increments on each edge where FlushE=1 and rst=0, whatever StallE is.
  - Saturates at all-ones.
- CntClr: zeroes both counters. It takes priority over a same-cycle increment (result is 0, not 1). It does not affect the pipeline fields.
- Reset mid-stall or mid-flush: rst wins, and the stage returns to all-zero in one cycle.
- A held instruction stays held for any number of stall cycles and resumes on the first edge with StallE=0.

Decomposition:
- Package pipe_pkg:
  - typedef ctrl_t, a packed struct of the control fields listed under CtrlD.
  - constant CTRL_NOP (all zero).
  - ResultSrc encodings (ALU, MEM, PC4).
  - ALUControl width constant.
- Sub-module sat_counter with parameter W and ports clk, rst, clr, inc, count. Two instances, one for StallCount and one for BubbleCount.
- Pipeline fields are kept in one always_ff, using the priority chain above.

Test Plan:
- Reset: drive rst=1 with all D inputs at non-zero values (PCD=0x100, CtrlD.RegWrite=1, funct3D=3'b101) -> the next edge gives all outputs 0, funct3E=0 and both counts 0.
- Plain load: ValidD=1, PCD=0x40, RdD=7, RegWrite=1, no stall or flush -> one edge later PCE=0x40, RdE=7, CtrlE.RegWrite=1, ValidE=1.
- Stall for 3 cycles: E holds PCE=0x40; D changes to PCD=0x44 during the stall -> PCE stays 0x40 for 3 edges and becomes 0x44 on the first unstalled edge. StallCount=3.
- Flush and stall together, with CLEAR_DATA_ON_FLUSH=0 and MemWrite=1 in D -> ValidE=0, CtrlE=CTRL_NOP, RdE=0, PCE=PCD, BubbleCount=1, StallCount unchanged.
- Counter saturation with CNT_WIDTH=4: 20 consecutive stall cycles -> StallCount=15. Then CntClr together with StallE -> StallCount=0.
- Invalid instruction: ValidD=0 with CtrlD.RegWrite=1, MemWrite=1, RdD=9 -> ValidE=0, CtrlE.RegWrite=0, CtrlE.MemWrite=0, RdE=0.
